// File: rtl/keccak_x_heep_pkg.sv
// Shared definitions for the Keccak accelerator integration into X-HEEP.
package keccak_x_heep_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4,
        DONE    = 3'd5
    } loader_state_e;

    localparam int unsigned WORD_BYTES = 4;

    // Slot of the loader on the external-master port array.
    localparam int unsigned KECCAK_LOADER_EXT_MASTER_IDX = 0;

endpackage

// File: rtl/obi_pkg.sv
// OBI bus request/response types shared by every X-HEEP bus initiator.
package obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/keccak_obi_loader.sv
// OBI initiator copying a block of 32-bit words, one read then one write per
// word, so the Keccak state/data windows can be filled without core traffic.
module keccak_obi_loader
    import obi_pkg::*;
    import keccak_x_heep_pkg::*;
#(
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [31:0]      src_addr_i,
    input  logic [31:0]      dst_addr_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             src_inc_i,
    input  logic             dst_inc_i,
    input  logic             intr_clr_i,
    output obi_req_t         master_req_o,
    input  obi_resp_t        master_resp_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             intr_o,
    output logic [LEN_W-1:0] words_done_o
);

    loader_state_e    state_q, state_d;
    logic [31:0]      cur_src_q;
    logic [31:0]      cur_dst_q;
    logic [31:0]      data_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] words_done_q;
    logic             src_inc_q;
    logic             dst_inc_q;
    logic             intr_q;
    logic             last_word;

    assign last_word = (words_done_q + LEN_W'(1)) == len_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Request fields are a pure function of state and the held registers,
    // so they cannot move while a request waits for its grant.
    always_comb begin
        state_d      = state_q;
        master_req_o = '0;
        unique case (state_q)
            IDLE: begin
                if (start_i) state_d = (len_i == '0) ? DONE : RD_REQ;
            end
            RD_REQ: begin
                master_req_o.req  = 1'b1;
                master_req_o.be   = 4'hF;
                master_req_o.addr = cur_src_q;
                if (master_resp_i.gnt) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (master_resp_i.rvalid) state_d = WR_REQ;
            end
            WR_REQ: begin
                master_req_o.req   = 1'b1;
                master_req_o.we    = 1'b1;
                master_req_o.be    = 4'hF;
                master_req_o.addr  = cur_dst_q;
                master_req_o.wdata = data_q;
                if (master_resp_i.gnt) state_d = WR_WAIT;
            end
            WR_WAIT: begin
                if (master_resp_i.rvalid) state_d = last_word ? DONE : RD_REQ;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cur_src_q    <= '0;
            cur_dst_q    <= '0;
            data_q       <= '0;
            len_q        <= '0;
            words_done_q <= '0;
            src_inc_q    <= 1'b0;
            dst_inc_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        cur_src_q    <= {src_addr_i[31:2], 2'b00};
                        cur_dst_q    <= {dst_addr_i[31:2], 2'b00};
                        len_q        <= len_i;
                        src_inc_q    <= src_inc_i;
                        dst_inc_q    <= dst_inc_i;
                        words_done_q <= '0;
                    end
                end
                RD_WAIT: begin
                    if (master_resp_i.rvalid) data_q <= master_resp_i.rdata;
                end
                WR_WAIT: begin
                    // Address arithmetic wraps modulo 2^32 on purpose.
                    if (master_resp_i.rvalid) begin
                        words_done_q <= words_done_q + LEN_W'(1);
                        if (src_inc_q) cur_src_q <= cur_src_q + 32'(WORD_BYTES);
                        if (dst_inc_q) cur_dst_q <= cur_dst_q + 32'(WORD_BYTES);
                    end
                end
                default: ;
            endcase
        end
    end

    // Set beats clear when both land in the DONE cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i)                 intr_q <= 1'b0;
        else if (state_q == DONE)  intr_q <= 1'b1;
        else if (intr_clr_i)       intr_q <= 1'b0;
    end

    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == DONE);
    assign intr_o       = intr_q | (state_q == DONE);
    assign words_done_o = words_done_q;

endmodule
